// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, ready-handshake instruction fetch, IR decode, next-PC select, halt/timeout fault
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             PCWre,
  input  logic [1:0]       PCSrc,
  input  logic [31:0]      imm_ext,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [5:0]       OP,
  output logic [5:0]       func,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       sa,
  output logic [15:0]      imm16,
  output logic [31:0]      curPC,
  output logic [31:0]      pc_plus4,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  // IDLE holds the fetch port quiet for the cycle after reset
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d, ir_q, ir_d, next_pc;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  assign pc_plus4 = pc_q + 32'd4;
  assign next_pc  = PCSrc == 2'b01 ? pc_plus4 + (imm_ext << 2)
                  : PCSrc == 2'b10 ? {pc_plus4[31:28], ir_q[25:0], 2'b00}
                  : pc_plus4;
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    fault_d   = fault_q;
    retired_d = retired_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          cnt_d   = '0;
          state_d = EXEC;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          state_d = HALT;
          fault_d = 1'b1;
        end else cnt_d = cnt_q + TW'(1);
      end
      EXEC: begin
        if (!PCWre || PCSrc == 2'b11) state_d = HALT;
        else begin
          pc_d      = next_pc;
          retired_d = retired_q + CNT_W'(1);
          state_d   = FETCH;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      cnt_q     <= '0;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end
  assign imem_req    = state_q == FETCH;
  assign instr_valid = state_q == EXEC;
  assign halted      = state_q == HALT;
  assign imem_addr   = pc_q;
  assign curPC       = pc_q;
  assign instr       = ir_q;
  assign fault       = fault_q;
  assign retired     = retired_q;
  assign OP          = ir_q[31:26];
  assign rs          = ir_q[25:21];
  assign rt          = ir_q[20:16];
  assign rd          = ir_q[15:11];
  assign sa          = ir_q[10:6];
  assign func        = ir_q[5:0];
  assign imm16       = ir_q[15:0];
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed checks of fetch/exec sequencing, next-PC selection, halt, timeout and reset
module tb_pc_fetch_unit;
  logic        clk = 0, rst_n = 0, pc_wre = 1, imem_ready = 0;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] imm_ext = 0, imem_rdata = 0;
  logic        imem_req, instr_valid, halted, fault;
  logic [31:0] imem_addr, instr, cur_pc, pc_plus4, retired;
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm16;
  logic        f_req, f_valid, f_halted, f_fault;
  logic [31:0] f_addr, f_instr, f_pc, f_pc4, f_retired;
  logic [5:0]  f_op, f_func;
  logic [4:0]  f_rs, f_rt, f_rd, f_sa;
  logic [15:0] f_imm16;
  logic [31:0] exp_ret;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  pc_fetch_unit u_dut (
    .CLK(clk), .Reset(rst_n), .PCWre(pc_wre), .PCSrc(pc_src), .imm_ext(imm_ext),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .OP(op), .func(func), .rs(rs), .rt(rt), .rd(rd),
    .sa(sa), .imm16(imm16), .curPC(cur_pc), .pc_plus4(pc_plus4), .halted(halted), .fault(fault),
    .retired(retired));

  pc_fetch_unit #(.TIMEOUT(4)) u_dut4 (
    .CLK(clk), .Reset(rst_n), .PCWre(pc_wre), .PCSrc(pc_src), .imm_ext(imm_ext),
    .imem_req(f_req), .imem_addr(f_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(f_valid), .instr(f_instr), .OP(f_op), .func(f_func), .rs(f_rs), .rt(f_rt), .rd(f_rd),
    .sa(f_sa), .imm16(f_imm16), .curPC(f_pc), .pc_plus4(f_pc4), .halted(f_halted), .fault(f_fault),
    .retired(f_retired));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; imem_ready = 0; pc_wre = 1; pc_src = 2'b00; imm_ext = 0;
    step(); step();
    exp_ret = 0;
    rst_n = 1;
    step();
  endtask

  task automatic run_instr(input string nm, input logic [31:0] word, input logic [1:0] src,
                           input logic [31:0] imm, input logic [31:0] exp_pc);
    n_cmp++;
    if (imem_req !== 1'b1) begin n_bad++; $display("FAIL %s fetch_req: got %b want 1", nm, imem_req); end
    imem_ready = 1; imem_rdata = word; pc_wre = 1; pc_src = src; imm_ext = imm;
    step();
    imem_ready = 0;
    n_cmp++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== word) begin
      n_bad++; $display("FAIL %s exec: valid=%b req=%b instr=%h want 1 0 %h", nm, instr_valid, imem_req, instr, word);
    end
    step();
    exp_ret = exp_ret + 1;
    n_cmp++;
    if (cur_pc !== exp_pc || imem_addr !== exp_pc || retired !== exp_ret || imem_req !== 1'b1) begin
      n_bad++; $display("FAIL %s next: pc=%h addr=%h ret=%0d req=%b want %h %h %0d 1",
                        nm, cur_pc, imem_addr, retired, imem_req, exp_pc, exp_pc, exp_ret);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; step(); step();
    n_cmp++;
    if (cur_pc !== 0 || instr !== 0 || imem_req !== 0 || instr_valid !== 0 || halted !== 0 ||
        fault !== 0 || retired !== 0 || op !== 0 || imm16 !== 0 || pc_plus4 !== 32'h4) begin
      n_bad++; $display("FAIL reset_state: pc=%h ir=%h req=%b val=%b h=%b f=%b ret=%0d p4=%h",
                        cur_pc, instr, imem_req, instr_valid, halted, fault, retired, pc_plus4);
    end
    exp_ret = 0;
    rst_n = 1; step();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_bad++; $display("FAIL reset_release: req=%b addr=%h want 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_seq_jump();
    imem_ready = 1; imem_rdata = 32'h2401_0005; pc_src = 2'b00;
    step();
    n_cmp++;
    if (op !== 6'd9 || rs !== 5'd0 || rt !== 5'd1 || imm16 !== 16'h0005) begin
      n_bad++; $display("FAIL decode_addiu: op=%0d rs=%0d rt=%0d imm=%h want 9 0 1 0005", op, rs, rt, imm16);
    end
    step();
    exp_ret = 1;
    run_instr("jump", 32'h0800_0010, 2'b10, 0, 32'h40);
    n_cmp++;
    if (retired !== 32'd2 || op !== 6'd2) begin
      n_bad++; $display("FAIL seq_retired: ret=%0d op=%0d want 2 2", retired, op);
    end
  endtask

  task automatic test_branch();
    run_instr("to_20", 32'h0800_0008, 2'b10, 0, 32'h20);
    run_instr("beq_neg", 32'h1000_FFFE, 2'b01, 32'hFFFF_FFFE, 32'h1C);
    run_instr("back_20", 32'h0800_0008, 2'b10, 0, 32'h20);
    run_instr("beq_pos", 32'h1000_0003, 2'b01, 32'h3, 32'h30);
    n_cmp++;
    if (rd !== 5'd0 || func !== 6'd3 || sa !== 5'd0) begin
      n_bad++; $display("FAIL decode_beq: rd=%0d func=%0d sa=%0d want 0 3 0", rd, func, sa);
    end
  endtask

  task automatic test_delayed_ready();
    imem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h30 || fault !== 1'b0) begin
        n_bad++; $display("FAIL wait_%0d: req=%b addr=%h fault=%b want 1 00000030 0", i, imem_req, imem_addr, fault);
      end
      step();
    end
    run_instr("late_ready", 32'h2401_0001, 2'b00, 0, 32'h34);
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (f_req !== 1'b1 || f_halted !== 1'b0) begin
        n_bad++; $display("FAIL to_fetch_%0d: req=%b halted=%b want 1 0", i, f_req, f_halted);
      end
      step();
    end
    n_cmp++;
    if (f_halted !== 1'b1 || f_fault !== 1'b1 || f_req !== 1'b0 || f_pc !== 0 || f_instr !== 0) begin
      n_bad++; $display("FAIL timeout_halt: h=%b f=%b req=%b pc=%h ir=%h want 1 1 0 0 0",
                        f_halted, f_fault, f_req, f_pc, f_instr);
    end
    n_cmp++;
    if (fault !== 1'b0 || imem_req !== 1'b1) begin
      n_bad++; $display("FAIL timeout16_nofault: f=%b req=%b want 0 1", fault, imem_req);
    end
    imem_ready = 1; imem_rdata = 32'h1234_5678;
    step(); step();
    imem_ready = 0;
    n_cmp++;
    if (f_halted !== 1'b1 || f_fault !== 1'b1 || f_instr !== 0 || f_valid !== 1'b0) begin
      n_bad++; $display("FAIL halt_frozen: h=%b f=%b ir=%h val=%b want 1 1 0 0", f_halted, f_fault, f_instr, f_valid);
    end
  endtask

  task automatic test_halt();
    do_reset();
    run_instr("h_a", 32'h2401_0001, 2'b00, 0, 32'h4);
    run_instr("h_b", 32'h2401_0002, 2'b00, 0, 32'h8);
    imem_ready = 1; imem_rdata = 32'hFC00_0000; pc_wre = 0; pc_src = 2'b11;
    step(); step(); step();
    imem_ready = 0;
    n_cmp++;
    if (halted !== 1'b1 || cur_pc !== 32'h8 || retired !== 32'd2 || fault !== 1'b0 ||
        imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'hFC00_0000) begin
      n_bad++; $display("FAIL halt_op: h=%b pc=%h ret=%0d f=%b req=%b val=%b ir=%h want 1 8 2 0 0 0 fc000000",
                        halted, cur_pc, retired, fault, imem_req, instr_valid, instr);
    end
    pc_wre = 1; pc_src = 2'b00;
  endtask

  task automatic test_reset_mid();
    rst_n = 0; step();
    n_cmp++;
    if (halted !== 0 || cur_pc !== 0 || retired !== 0 || imem_req !== 0) begin
      n_bad++; $display("FAIL reset_in_halt: h=%b pc=%h ret=%0d req=%b want 0 0 0 0", halted, cur_pc, retired, imem_req);
    end
    do_reset();
    run_instr("pre_mid", 32'h2401_0001, 2'b00, 0, 32'h4);
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (f_fault !== 1'b1 || imem_req !== 1'b1) begin
      n_bad++; $display("FAIL mid_setup: f4=%b req=%b want 1 1", f_fault, imem_req);
    end
    rst_n = 0; step();
    n_cmp++;
    if (cur_pc !== 0 || retired !== 0 || imem_req !== 0 || fault !== 0 || f_fault !== 0 || f_halted !== 0) begin
      n_bad++; $display("FAIL reset_mid_fetch: pc=%h ret=%0d req=%b f=%b f4=%b h4=%b want 0 0 0 0 0 0",
                        cur_pc, retired, imem_req, fault, f_fault, f_halted);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    run_instr("to_top", 32'h1000_FFFE, 2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFC);
    n_cmp++;
    if (pc_plus4 !== 32'h0) begin
      n_bad++; $display("FAIL pc4_wrap: got %h want 00000000", pc_plus4);
    end
    run_instr("wrap", 32'h2401_0001, 2'b00, 0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_seq_jump();
    test_branch();
    test_delayed_ready();
    test_timeout();
    test_halt();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
